// File: rtl/arm_mc_controller.sv
// Multicycle control unit for the ARM-subset core: FSM sequencing, NZCV flags, condition check.
// Optional BX state is compiled in when ARM_MC_BX_EN is defined.
module arm_mc_controller #(
    parameter int unsigned MEM_LAT   = 0,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned ALUCTRL_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           Cond,
    input  logic [1:0]           Op,
    input  logic [5:0]           Funct,
    input  logic [3:0]           Rd,
    input  logic [3:0]           ALUFlags,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic                 LinkWrite,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [3:0]           Flags,
    output logic [3:0]           state_dbg
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_BX     = 4'd10
    } state_t;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_BX  = 4'b1001;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       flags_q, flags_d;
    logic             cond_ok_q, cond_ok_d;

    logic       fn_i, fn_s;
    logic [3:0] cmd;
    logic       lat_done;
    logic       cond_ex;
    logic       n_f, z_f, c_f, v_f;

    logic                 pc_write, adr_src, mem_write, ir_write, reg_write, link_write;
    logic                 alu_src_a;
    logic [1:0]           alu_src_b, result_src, imm_src, reg_src;
    logic [ALUCTRL_W-1:0] alu_ctrl;

    assign fn_i     = Funct[5];
    assign cmd      = Funct[4:1];
    assign fn_s     = Funct[0];
    assign lat_done = (cnt_q == CNT_W'(MEM_LAT));
    assign {n_f, z_f, c_f, v_f} = flags_q;

    always_comb begin
        cond_ex = 1'b0;
        case (Cond)
            4'h0: cond_ex = z_f;
            4'h1: cond_ex = ~z_f;
            4'h2: cond_ex = c_f;
            4'h3: cond_ex = ~c_f;
            4'h4: cond_ex = n_f;
            4'h5: cond_ex = ~n_f;
            4'h6: cond_ex = v_f;
            4'h7: cond_ex = ~v_f;
            4'h8: cond_ex = c_f & ~z_f;
            4'h9: cond_ex = ~c_f | z_f;
            4'hA: cond_ex = (n_f == v_f);
            4'hB: cond_ex = (n_f != v_f);
            4'hC: cond_ex = ~z_f & (n_f == v_f);
            4'hD: cond_ex = z_f | (n_f != v_f);
            4'hE: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            flags_q   <= '0;
            cond_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            flags_q   <= flags_d;
            cond_ok_q <= cond_ok_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        flags_d    = flags_q;
        cond_ok_d  = cond_ok_q;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        link_write = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        alu_ctrl   = '0;
        // Immediate format and register-read steering follow the instruction register directly.
        imm_src    = Op;
        reg_src    = {(Op == 2'b01) && !fn_s, (Op == 2'b10)};

        case (state_q)
            S_FETCH: begin
                if (lat_done) begin
                    ir_write   = 1'b1;
                    alu_src_a  = 1'b1;
                    alu_src_b  = 2'b10;
                    alu_ctrl   = ALUCTRL_W'(CMD_ADD);
                    result_src = 2'b10;
                    pc_write   = 1'b1;
                    state_d    = S_DECODE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                alu_ctrl   = ALUCTRL_W'(CMD_ADD);
                result_src = 2'b10;
                cond_ok_d  = cond_ex;
                if (!cond_ex) begin
                    state_d = S_FETCH;
                end else begin
                    case (Op)
                        2'b01: state_d = S_MEMADR;
                        2'b00: begin
                            if (fn_i) begin
                                state_d = S_EXECI;
                            end else begin
`ifdef ARM_MC_BX_EN
                                state_d = (cmd == CMD_BX) ? S_BX : S_EXECR;
`else
                                state_d = S_EXECR;
`endif
                            end
                        end
                        2'b10:   state_d = S_BRANCH;
                        default: state_d = S_FETCH;
                    endcase
                end
            end
            S_EXECR, S_EXECI: begin
                alu_src_b = (state_q == S_EXECI) ? 2'b01 : 2'b00;
                alu_ctrl  = (cmd == CMD_CMP) ? ALUCTRL_W'(CMD_SUB) : ALUCTRL_W'(cmd);
                if (fn_s && cond_ok_q) begin
                    flags_d[3:2] = ALUFlags[3:2];
                    if (cmd == CMD_ADD || cmd == CMD_SUB || cmd == CMD_CMP) begin
                        flags_d[1:0] = ALUFlags[1:0];
                    end
                end
                state_d = (cmd == CMD_CMP) ? S_FETCH : S_ALUWB;
            end
            S_ALUWB, S_MEMWB: begin
                result_src = (state_q == S_MEMWB) ? 2'b01 : 2'b00;
                if (cond_ok_q) begin
                    if (Rd == 4'd15) pc_write  = 1'b1;
                    else             reg_write = 1'b1;
                end
                state_d = S_FETCH;
            end
            S_MEMADR: begin
                alu_src_b = 2'b01;
                alu_ctrl  = ALUCTRL_W'(CMD_ADD);
                state_d   = fn_s ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                adr_src = 1'b1;
                if (lat_done) state_d = S_MEMWB;
                else          cnt_d   = cnt_q + CNT_W'(1);
            end
            S_MEMWR: begin
                adr_src   = 1'b1;
                mem_write = cond_ok_q;
                if (lat_done) state_d = S_FETCH;
                else          cnt_d   = cnt_q + CNT_W'(1);
            end
            S_BRANCH: begin
                alu_src_b  = 2'b01;
                alu_ctrl   = ALUCTRL_W'(CMD_ADD);
                result_src = 2'b10;
                pc_write   = cond_ok_q;
                link_write = cmd[3] & cond_ok_q;
                state_d    = S_FETCH;
            end
`ifdef ARM_MC_BX_EN
            S_BX: begin
                alu_src_b  = 2'b00;
                alu_ctrl   = ALUCTRL_W'(CMD_MOV);
                result_src = 2'b10;
                pc_write   = cond_ok_q;
                state_d    = S_FETCH;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Reset forces every output low regardless of the state decode.
    assign PCWrite    = rst_n & pc_write;
    assign AdrSrc     = rst_n & adr_src;
    assign MemWrite   = rst_n & mem_write;
    assign IRWrite    = rst_n & ir_write;
    assign RegWrite   = rst_n & reg_write;
    assign LinkWrite  = rst_n & link_write;
    assign ALUSrcA    = rst_n & alu_src_a;
    assign ALUSrcB    = rst_n ? alu_src_b  : '0;
    assign ResultSrc  = rst_n ? result_src : '0;
    assign ImmSrc     = rst_n ? imm_src    : '0;
    assign RegSrc     = rst_n ? reg_src    : '0;
    assign ALUControl = rst_n ? alu_ctrl   : '0;
    assign Flags      = rst_n ? flags_q    : '0;
    assign state_dbg  = rst_n ? state_q    : '0;

endmodule

// File: tb/tb_arm_mc_controller.sv
// Table-driven bench for arm_mc_controller: three instances at MEM_LAT 0/1/2 share stimulus.
module tb_arm_mc_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] Cond = '0;
    logic [1:0] Op = '0;
    logic [5:0] Funct = '0;
    logic [3:0] Rd = '0;
    logic [3:0] ALUFlags = '0;

    // {state[26:23], flags[22:19], PCW,Adr,MemW,IRW,RegW,Link[18:13], SrcA,SrcB,Res,ALUC[12:4], ImmSrc,RegSrc[3:0]}
    logic [26:0] obs [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic       pcw, adr, memw, irw, regw, linkw, srca;
        logic [1:0] srcb, res, imm, rsrc;
        logic [3:0] aluc, flg, st;

        arm_mc_controller #(.MEM_LAT(g), .CNT_W(4), .ALUCTRL_W(4)) u_dut (
            .clk(clk), .rst_n(rst_n), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
            .ALUFlags(ALUFlags), .PCWrite(pcw), .AdrSrc(adr), .MemWrite(memw),
            .IRWrite(irw), .RegWrite(regw), .LinkWrite(linkw), .ALUSrcA(srca),
            .ALUSrcB(srcb), .ResultSrc(res), .ImmSrc(imm), .RegSrc(rsrc),
            .ALUControl(aluc), .Flags(flg), .state_dbg(st)
        );

        assign obs[g] = {st, flg, pcw, adr, memw, irw, regw, linkw, srca, srcb, res, aluc, imm, rsrc};
    end

    typedef struct {
        bit         rst;
        int         lat;
        logic [3:0] cond;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        logic [3:0] alf;
        logic [3:0] st;
        logic [5:0] stb;
        logic [3:0] flg;
        bit         cdp;
        logic [8:0] dp;
        bit         cdec;
        logic [3:0] dec;
    } row_t;

    row_t rows[$];
    row_t cur;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic ins(input int lat, input logic [3:0] c, input logic [1:0] o,
                       input logic [5:0] f, input logic [3:0] r, input logic [3:0] a);
        cur.rst = 1'b1; cur.lat = lat; cur.cond = c; cur.op = o;
        cur.funct = f; cur.rd = r; cur.alf = a;
    endtask

    task automatic nxt(input logic [3:0] c, input logic [1:0] o,
                       input logic [5:0] f, input logic [3:0] r, input logic [3:0] a);
        cur.cond = c; cur.op = o; cur.funct = f; cur.rd = r; cur.alf = a;
    endtask

    task automatic e(input logic [3:0] st, input logic [5:0] stb, input logic [3:0] flg);
        row_t r;
        r = cur;
        r.st = st; r.stb = stb; r.flg = flg;
        r.cdp = 1'b0; r.dp = '0; r.cdec = 1'b0; r.dec = '0;
        rows.push_back(r);
        cur.rst = 1'b0;
    endtask

    task automatic dp(input logic [8:0] v);
        rows[rows.size()-1].cdp = 1'b1;
        rows[rows.size()-1].dp  = v;
    endtask

    task automatic dec(input logic [3:0] v);
        rows[rows.size()-1].cdec = 1'b1;
        rows[rows.size()-1].dec  = v;
    endtask

    task automatic check(input string nm, input int idx, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %b expected %b", nm, idx, got, want);
        end
    endtask

    task automatic drv(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                       input logic [3:0] r, input logic [3:0] a);
        Cond = c; Op = o; Funct = f; Rd = r; ALUFlags = a;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // ADD immediate, MEM_LAT=0
        ins(0, 4'hE, 2'b00, 6'b101000, 4'd1, 4'h0);
        e(4'd0, 6'b100100, 4'h0); dp(9'b1_10_10_0100);
        e(4'd1, 6'b000000, 4'h0); dec(4'b00_00);
        e(4'd7, 6'b000000, 4'h0); dp(9'b0_01_00_0100);
        e(4'd8, 6'b000010, 4'h0); dp(9'b0_00_00_0000);
        e(4'd0, 6'b100100, 4'h0);
        // CMP -> flags 0110, then BEQ taken, BNE not taken, then ANDS (N/Z only)
        ins(0, 4'hE, 2'b00, 6'b010101, 4'd0, 4'h6);
        e(4'd0, 6'b100100, 4'h0);
        e(4'd1, 6'b000000, 4'h0); dec(4'b00_00);
        e(4'd6, 6'b000000, 4'h0); dp(9'b0_00_00_0010);
        nxt(4'h0, 2'b10, 6'b100000, 4'd0, 4'h9);
        e(4'd0, 6'b100100, 4'h6);
        e(4'd1, 6'b000000, 4'h6); dec(4'b10_01);
        e(4'd9, 6'b100000, 4'h6); dp(9'b0_01_10_0100);
        nxt(4'h1, 2'b10, 6'b100000, 4'd0, 4'h9);
        e(4'd0, 6'b100100, 4'h6);
        e(4'd1, 6'b000000, 4'h6);
        e(4'd0, 6'b100100, 4'h6);
        nxt(4'hE, 2'b00, 6'b000001, 4'd2, 4'hB);
        e(4'd1, 6'b000000, 4'h6);
        e(4'd6, 6'b000000, 4'h6); dp(9'b0_00_00_0000);
        e(4'd8, 6'b000010, 4'hA);
        e(4'd0, 6'b100100, 4'hA);
        // LDR to R15, MEM_LAT=2
        ins(2, 4'hE, 2'b01, 6'b011001, 4'd15, 4'h0);
        e(4'd0, 6'b000000, 4'h0);
        e(4'd0, 6'b000000, 4'h0);
        e(4'd0, 6'b100100, 4'h0); dp(9'b1_10_10_0100);
        e(4'd1, 6'b000000, 4'h0); dec(4'b01_00);
        e(4'd2, 6'b000000, 4'h0); dp(9'b0_01_00_0100);
        e(4'd3, 6'b010000, 4'h0);
        e(4'd3, 6'b010000, 4'h0);
        e(4'd3, 6'b010000, 4'h0);
        e(4'd4, 6'b100000, 4'h0); dp(9'b0_00_01_0000);
        e(4'd0, 6'b000000, 4'h0);
        // STR, MEM_LAT=1
        ins(1, 4'hE, 2'b01, 6'b011000, 4'd3, 4'h0);
        e(4'd0, 6'b000000, 4'h0);
        e(4'd0, 6'b100100, 4'h0);
        e(4'd1, 6'b000000, 4'h0); dec(4'b01_10);
        e(4'd2, 6'b000000, 4'h0);
        e(4'd5, 6'b011000, 4'h0);
        e(4'd5, 6'b011000, 4'h0);
        e(4'd0, 6'b000000, 4'h0);
        // BL, MEM_LAT=0
        ins(0, 4'hE, 2'b10, 6'b110000, 4'd0, 4'h0);
        e(4'd0, 6'b100100, 4'h0);
        e(4'd1, 6'b000000, 4'h0);
        e(4'd9, 6'b100001, 4'h0); dp(9'b0_01_10_0100);
        e(4'd0, 6'b100100, 4'h0);
        // BX encoding (I=0, cmd=1001, S=0)
        ins(0, 4'hE, 2'b00, 6'b010010, 4'd0, 4'h0);
        e(4'd0, 6'b100100, 4'h0);
        e(4'd1, 6'b000000, 4'h0);
`ifdef ARM_MC_BX_EN
        e(4'd10, 6'b100000, 4'h0); dp(9'b0_00_10_1101);
`else
        e(4'd6, 6'b000000, 4'h0); dp(9'b0_00_00_1001);
        e(4'd8, 6'b000010, 4'h0);
`endif
        e(4'd0, 6'b100100, 4'h0);

        @(negedge clk);
        foreach (rows[i]) begin
            if (rows[i].rst) do_reset();
            drv(rows[i].cond, rows[i].op, rows[i].funct, rows[i].rd, rows[i].alf);
            #1;
            check("state/strobes/flags", i, 32'(obs[rows[i].lat][26:13]),
                  32'({rows[i].st, rows[i].flg, rows[i].stb}));
            if (rows[i].cdp)
                check("datapath selects", i, 32'(obs[rows[i].lat][12:4]), 32'(rows[i].dp));
            if (rows[i].cdec)
                check("imm/reg src", i, 32'(obs[rows[i].lat][3:0]), 32'(rows[i].dec));
            @(negedge clk);
        end

        // Asynchronous reset during the second MEMRD wait cycle, MEM_LAT=2
        do_reset();
        drv(4'hE, 2'b00, 6'b010101, 4'd0, 4'h6);
        repeat (5) @(negedge clk);
        drv(4'hE, 2'b01, 6'b011001, 4'd1, 4'h0);
        repeat (6) @(negedge clk);
        #1;
        check("pre-reset MEMRD", 100, 32'({obs[2][26:19], obs[2][17]}), 32'({4'd3, 4'h6, 1'b1}));
        #2;
        rst_n = 1'b0;
        #1;
        check("outputs in reset", 101, 32'(obs[2]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post-reset state/flags", 102, 32'(obs[2][26:19]), 32'd0);
        check("post-reset fetch strobes", 103, 32'(obs[2][18:13]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("fetch final after reset", 104, 32'({obs[2][26:23], obs[2][18:13]}),
              32'({4'd0, 6'b100100}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/arm_mc_controller.md
Name: arm_mc_controller

Overview:
- Multicycle control unit for the ARM-subset core; the successor to the single-cycle decoder.
- Sequences each instruction through a state machine that shares one ALU and one memory.
- Holds the NZCV flags and evaluates the condition code once per instruction, in DECODE.
- Memory latency is parametrised: fetch, load and store states hold for a programmable number of wait cycles.

Parameters:
MEM_LAT, 0, memory wait cycles; each memory access occupies MEM_LAT+1 cycles
CNT_W, 4, wait-counter width; MEM_LAT must be < 2^CNT_W
ALUCTRL_W, 4, ALUControl width (>=4); cmd is zero-extended to this width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
Cond  in  4  instruction condition field [31:28]
Op  in  2  instruction class [27:26]
Funct  in  6  [25:20]: I, cmd[3:0], S
Rd  in  4  destination register
ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
PCWrite  out  1  load PC from Result
AdrSrc  out  1  0=PC, 1=ALU result register as memory address
MemWrite  out  1  data memory write
IRWrite  out  1  instruction register load
RegWrite  out  1  register file write to Rd
LinkWrite  out  1  write PC+4 into R14
ALUSrcA  out  1  0=RD1, 1=PC
ALUSrcB  out  2  00=RD2, 01=Ext, 10=constant 4
ResultSrc  out  2  00=ALUOut reg, 01=Data reg, 10=ALU direct
ImmSrc  out  2  00 DP, 01 MEM, 10 BRANCH
RegSrc  out  2  [0]=branch (read PC), [1]=store (read Rd)
ALUControl  out  ALUCTRL_W  ALU operation
Flags  out  4  registered {N,Z,C,V}
state_dbg  out  4  current state encoding

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, BX=10.
- Reset (rst_n low, asynchronous): state FETCH, wait counter 0, Flags 0000, cond_ok 0. While rst_n is low, every output is 0; this overrides any state output. Reset is honoured mid-instruction, including during a memory wait.
- Wait counter: in FETCH, MEMRD and MEMWR, the counter increments each cycle. The state advances on the cycle where counter==MEM_LAT, and the counter clears on every state exit.
- FETCH: AdrSrc=0 on every cycle. The final cycle also drives IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD(0100), ResultSrc=10, PCWrite=1. Next state DECODE.
- DECODE:
  - Drives ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (PC+8 onto the R15 read path); ImmSrc and RegSrc are decoded from Op and Funct.
  - Condition evaluation: CondEx is computed from the registered Flags using the standard ARM table (0x0 EQ through 0xE AL; 0xF never) and latched into cond_ok.
  - If CondEx=0, next state is FETCH; no write strobe asserts for that instruction.
  - Otherwise next state by Op: 01→MEMADR; 00 with I=1→EXECI; 00 with I=0→EXECR (or BX, see Optional Feature); 10→BRANCH; 11→FETCH (undefined instruction, no writes).
- EXECR / EXECI: ALUSrcA=0; ALUSrcB=00 (EXECR) or 01 (EXECI); ALUControl=cmd, except CMP (1010) drives SUB (0010).
  - Flag update at this edge, only when S=1: N and Z load from ALUFlags.
  - C and V additionally load only when cmd ∈ {0100, 0010, 1010}.
  - Next state FETCH when cmd=1010 (no writeback); otherwise ALUWB.
- ALUWB / MEMWB: ResultSrc=00 (ALUWB) or 01 (MEMWB).
  - Rd≠15: RegWrite=1.
  - Rd=15: PCWrite=1 and RegWrite=0.
  - Next state FETCH.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=ADD. Next state MEMRD if S=1, else MEMWR.
- MEMRD: AdrSrc=1 for MEM_LAT+1 cycles, then MEMWB.
- MEMWR: AdrSrc=1 and MemWrite=1 for MEM_LAT+1 cycles, then FETCH.
- BRANCH (single cycle, then FETCH): ALUSrcA=0, ALUSrcB=01, ALUControl=ADD, ResultSrc=10, PCWrite=1. LinkWrite=1 when cmd[3]=1 (BL).
- Flags change only in EXECR/EXECI. An illegal state encoding recovers to FETCH on the next edge.
- Latency with MEM_LAT=0: DP 4 cycles, CMP 3, LDR 5, STR 4, B 3, condition-failed 2.

Optional Feature:
- Macro: ARM_MC_BX_EN.
- Defined: Op=00, I=0, cmd=1001 enters state BX. BX drives ALUSrcB=00, ALUControl=1101 (pass RD2), ResultSrc=10, PCWrite=1, then FETCH. No register write and no flag update.
- Undefined: cmd=1001 is an ordinary DP operation through EXECR→ALUWB with ALUControl=1001. State 10 is unreachable.

Test Plan:
- Reset in MEMRD (MEM_LAT=2, second wait cycle), rst_n=0 → outputs all 0 immediately; Flags=0000; state_dbg=0 after release.
- ADD imm (Cond=E, Op=00, Funct=101000, Rd=1), MEM_LAT=0 → states 0,1,7,8; ALUControl=0100 in EXECI; RegWrite=1 only in cycle 4.
- CMP (Funct=010101) with ALUFlags=0110 → 3 cycles, Flags=0110, no RegWrite. Then BEQ (Cond=0) → BRANCH with PCWrite=1. Then BNE (Cond=1) → DECODE→FETCH with no PCWrite.
- LDR (Op=01, S=1, Rd=15), MEM_LAT=2 → FETCH 3 cycles, MEMRD 3 cycles with AdrSrc=1; MEMWB has PCWrite=1, RegWrite=0; 9 cycles total.
- STR (S=0), MEM_LAT=1 → MemWrite=1 for exactly 2 consecutive cycles; RegSrc=10 in DECODE.
- BL (Op=10, Funct=110000) → LinkWrite=1 and PCWrite=1 in BRANCH. BX (Funct=010010) with ARM_MC_BX_EN → state 10, PCWrite=1, RegWrite=0; without the macro → states 6,8 with RegWrite=1.
